// File: rtl/ftsd_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ftsd_scan_ctrl_pkg;

  localparam int         FTSD_DIGITS = 4;
  localparam int         FTSD_SEL_W  = 2;
  localparam logic [3:0] FTSD_AN_OFF = 4'b1111;

  // S_BLANK: every anode dark (anti-ghost gap). S_SHOW: selected digit may be lit.
  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  // Digit set is packed {d0,d1,d2,d3}; d0 is the leftmost digit in bits [15:12].
  function automatic logic [3:0] pick_digit(input logic [15:0] d, input logic [1:0] sel);
    logic [3:0] n;
    case (sel)
      2'd0:    n = d[15:12];
      2'd1:    n = d[11:8];
      2'd2:    n = d[7:4];
      default: n = d[3:0];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ftsd_scan_ctrl_if.sv
// Update handshake plus scan outputs of the seven-segment scan controller.
// Handshake: a digit set transfers on every clock edge where upd_valid && upd_ready;
// the producer holds upd_data stable while upd_valid is high and not yet accepted,
// and may change it freely afterwards. upd_ready stays low while an update is pending.
interface ftsd_scan_ctrl_if;
  import ftsd_scan_ctrl_pkg::*;

  logic        upd_valid;
  logic [15:0] upd_data;
  logic        upd_ready;
  logic [1:0]  scan_sel;
  logic [3:0]  digit_out;
  logic        an_en;
  logic        frame_done;
  state_t      dbg_state;

  modport master (
    output upd_valid, upd_data,
    input  upd_ready, scan_sel, digit_out, an_en, frame_done, dbg_state
  );

  modport slave (
    input  upd_valid, upd_data,
    output upd_ready, scan_sel, digit_out, an_en, frame_done, dbg_state
  );
endinterface

// File: rtl/ftsd_slot_timer.sv
// Load/count/terminal-count timer shared by the blank gap and the digit dwell.
module ftsd_slot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Count up from zero; load restarts the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Terminal count marks the last cycle of the current phase (limit = length - 1).
  assign tc = (cnt == limit);

endmodule

// File: rtl/ftsd_scan_ctrl.sv
// Scan sequencer for a 4-digit seven-segment display: digit select, blank/dwell
// timing, frame-aligned commit of new digit sets and leading-zero blanking.
module ftsd_scan_ctrl
  import ftsd_scan_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DWELL = 50000,
  parameter int BLANK = 500,
  parameter int LZB   = 1
) (
  input  logic clk,
  input  logic rst,
  ftsd_scan_ctrl_if.slave bus
);

  localparam state_t           RST_STATE = (BLANK == 0) ? S_SHOW : S_BLANK;
  localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_t      state, state_nxt;
  logic [1:0]  sel, sel_nxt;
  logic [15:0] active, active_nxt, shadow;
  logic        pending, ready_q;
  logic        an_q, fd_q;
  logic [3:0]  dig_q;
  logic        tc, boundary, accept, commit, lit_nxt;
  logic [2:0]  seen;
  logic [CNT_W-1:0] limit;

  // The timer compares against the length of whichever phase is running.
  assign limit = (state == S_SHOW) ? DWELL_LIM : BLANK_LIM;

  ftsd_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tc),
    .limit (limit),
    .tc    (tc)
  );

  // Next-state logic: phase change on terminal count, digit advance at slot end.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    boundary  = 1'b0;
    case (state)
      S_BLANK: begin
        if (tc) state_nxt = S_SHOW;
      end
      default: begin
        if (tc) begin
          sel_nxt   = sel + 2'd1;
          state_nxt = (BLANK == 0) ? S_SHOW : S_BLANK;
          boundary  = (sel == 2'b11);
        end
      end
    endcase
  end

  // Only one update can be outstanding, so accept and commit never coincide.
  assign accept     = bus.upd_valid && ready_q;
  assign commit     = boundary && pending;
  assign active_nxt = commit ? shadow : active;

  // Leading-zero mask: seen[i] = any of d0..di non-zero (A-F count as non-zero).
  always_comb begin
    seen    = '0;
    seen[0] = |active_nxt[15:12];
    seen[1] = seen[0] | (|active_nxt[11:8]);
    seen[2] = seen[1] | (|active_nxt[7:4]);
    case (sel_nxt)
      2'd0:    lit_nxt = (LZB == 0) || seen[0];
      2'd1:    lit_nxt = (LZB == 0) || seen[1];
      2'd2:    lit_nxt = (LZB == 0) || seen[2];
      default: lit_nxt = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  // Datapath and registered outputs, all computed from next-cycle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= 2'b00;
      active  <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
      ready_q <= 1'b1;
      an_q    <= 1'b0;
      dig_q   <= 4'h0;
      fd_q    <= 1'b0;
    end else begin
      sel    <= sel_nxt;
      active <= active_nxt;
      if (accept) begin
        shadow  <= bus.upd_data;
        pending <= 1'b1;
        ready_q <= 1'b0;
      end else if (commit) begin
        pending <= 1'b0;
        ready_q <= 1'b1;
      end
      an_q  <= (state_nxt == S_SHOW) && lit_nxt;
      dig_q <= pick_digit(active_nxt, sel_nxt);
      fd_q  <= boundary;
    end
  end

  assign bus.upd_ready  = ready_q;
  assign bus.scan_sel   = sel;
  assign bus.digit_out  = dig_q;
  assign bus.an_en      = an_q;
  assign bus.frame_done = fd_q;
  assign bus.dbg_state  = state;

endmodule
